alu_result_queue: RTL and testbench
===================================

# alu_result_queue

Parametrised successor of the ALU result selector. Each accepted operation selects one of four unit results by `op_sel`, derives zero/negative flags and a result-class tag, and stores all of it in a DEPTH-entry FIFO with valid/ready on both sides. It sits between the ALU units and the register write-back or bus stage, so a stalled consumer no longer corrupts or drops ALU results.

## Interface
- `WIDTH`, 8: datapath width of every result port; ≥2.
- `DEPTH`, 2: FIFO entries; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: producer presents an operation.
- `in_ready` out 1: queue can accept this cycle.
- `op_sel` in 4: operation code.
- `arith_res` in WIDTH: arithmetic unit result.
- `logic_res` in WIDTH: logic unit result.
- `cmp_res` in WIDTH: comparator result.
- `shift_res` in WIDTH: shifter result.
- `out_valid` out 1: head entry is valid.
- `out_ready` in 1: consumer takes the head entry this cycle.
- `result` out WIDTH: head entry result.
- `flag_z` out 1: head result == 0.
- `flag_n` out 1: head result MSB.
- `res_class` out 2: head class; 00 arith, 01 logic, 10 cmp, 11 shift.
- `count` out $clog2(DEPTH+1): entries currently held.

Reset: synchronous, active-high; one clock domain.

## Operation
- Selection decode, evaluated on input:
  - arith for `op_sel` 0–2 and 8.
  - logic for 3–6.
  - shift for 12–13.
  - cmp for 7, 9, 10, 11, 14, 15.
  - Every code maps; there is no zero default.
- Flags are computed from the selected value at push time and stored with it. `flag_z` = (selected == 0). `flag_n` = selected[WIDTH-1].
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- `in_ready` = (`count` < DEPTH). It is combinational from `count` only and never depends on `out_ready`.
- `out_valid` = (`count` != 0).
- Storage is a circular buffer with write pointer, read pointer and `count`. Both pointers wrap from DEPTH-1 to 0.
- Simultaneous push and pop:
  - `count` is unchanged.
  - Both pointers advance.
  - The popped entry is the old head, never the pushed entry, including when `count`==1.
- When full, `in_ready`=0 and input is ignored regardless of `out_ready`. A same-cycle pop frees space for the next cycle only.
- Pop when empty cannot occur, because `out_valid`=0.
- While `out_valid`=0, `result`, `flag_z`, `flag_n` and `res_class` are forced to 0. `flag_z` is not 1 when empty.
- While `out_valid`=1 and `out_ready`=0, head outputs are stable.
- Reset state:
  - `count`=0, pointers=0.
  - `out_valid`=0, `in_ready`=1.
  - `result`=0, flags=0, `res_class`=00.
- Reset mid-operation discards all entries. A push presented in the reset cycle is dropped.

## Timing
- Latency is 1 cycle. A push at edge N appears on the outputs after edge N (`out_valid`=1 in cycle N+1) when the queue was empty.
- Sustained throughput is one operation per cycle while `out_ready`=1, for any DEPTH ≥2.
- `count` updates on the clock edge following the push/pop decision.
- Inputs `op_sel` and the `*_res` ports are sampled only on push edges.
- No combinational path exists from `out_ready` to `in_ready`.
- Combinational paths exist only from `count`/storage to outputs; data outputs come from the stored head.

## Test plan
- Decode sweep:
  - Stimulus: WIDTH=8, `out_ready`=1, `arith_res`=0x11, `logic_res`=0x22, `cmp_res`=0x33, `shift_res`=0x44, `op_sel` 0..15 on consecutive cycles.
  - Required output: 11,11,11,22,22,22,22,33,11,33,33,33,44,44,33,33, with classes 00/01/10/11 to match.
  - Required: one result per cycle, no bubbles.
- Flags:
  - Push arith 0x00: `flag_z`=1, `flag_n`=0.
  - Push arith 0x80: `flag_z`=0, `flag_n`=1.
  - After draining: all outputs 0, `flag_z`=0.
- Backpressure/full, DEPTH=2, `out_ready`=0:
  - Push A=0x05 and B=0x06: `count`=2, `in_ready`=0.
  - Third push C is ignored.
  - Raise `out_ready`: outputs A then B.
  - `count` goes 2→1→0. C never appears.
- Simultaneous push/pop:
  - With `count`=1 (head 0x0A), push 0x0B while popping.
  - Required: 0x0A is consumed, `count` stays 1, head becomes 0x0B next cycle.
  - Repeat at `count`=DEPTH-1 with DEPTH=4, crossing the pointer wrap.
- Reset mid-stream:
  - Fill 2 entries, assert `rst` for one cycle together with `in_valid`=1.
  - Required next cycle: `count`=0, `out_valid`=0, `in_ready`=1, `result`=0.
  - The pushed value is absent.
- Parametrisation:
  - WIDTH=16, DEPTH=8: push 8 values 0x8000..0x8007 with `out_ready`=0; `in_ready`=0 after the 8th.
  - Drain: values return in order, each with `flag_n`=1.

Source files
------------

// File: rtl/alu_result_queue.sv
// ALU result queue: selects one of four unit results by op_sel, tags it with flags/class, buffers it in a FIFO.
// Latency: 1 cycle from push to head outputs on an empty queue; full throughput with simultaneous push/pop.
// Backpressure: in_ready depends only on count (never on out_ready); head outputs hold while out_ready is low.
module alu_result_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [3:0]                 op_sel,
   input  logic [WIDTH-1:0]           arith_res,
   input  logic [WIDTH-1:0]           logic_res,
   input  logic [WIDTH-1:0]           cmp_res,
   input  logic [WIDTH-1:0]           shift_res,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           result,
   output logic                       flag_z,
   output logic                       flag_n,
   output logic [1:0]                 res_class,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   localparam logic [1:0] CLS_ARITH = 2'b00;
   localparam logic [1:0] CLS_LOGIC = 2'b01;
   localparam logic [1:0] CLS_CMP   = 2'b10;
   localparam logic [1:0] CLS_SHIFT = 2'b11;

   typedef struct packed {
      logic [WIDTH-1:0] res;
      logic             z;
      logic             n;
      logic [1:0]       cls;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   cnt;
   entry_t          in_entry;
   entry_t          head;
   logic            push;
   logic            pop;

   // Every opcode maps to a unit; the comparator owns all codes not listed explicitly.
   always_comb begin
      in_entry.cls = CLS_CMP;
      in_entry.res = cmp_res;
      case (op_sel)
         4'd0, 4'd1, 4'd2, 4'd8: begin
            in_entry.cls = CLS_ARITH;
            in_entry.res = arith_res;
         end
         4'd3, 4'd4, 4'd5, 4'd6: begin
            in_entry.cls = CLS_LOGIC;
            in_entry.res = logic_res;
         end
         4'd12, 4'd13: begin
            in_entry.cls = CLS_SHIFT;
            in_entry.res = shift_res;
         end
         default: begin
            in_entry.cls = CLS_CMP;
            in_entry.res = cmp_res;
         end
      endcase
      in_entry.z = (in_entry.res == '0);
      in_entry.n = in_entry.res[WIDTH-1];
   end

   assign in_ready  = (cnt < CW'(DEPTH));
   assign out_valid = (cnt != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign count     = cnt;

   // DEPTH is a power of two, so natural pointer overflow wraps DEPTH-1 to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr] <= in_entry;
      end
   end

   // Head fields are zeroed when empty so stale storage never leaks out.
   assign head      = mem[rd_ptr];
   assign result    = out_valid ? head.res : '0;
   assign flag_z    = out_valid ? head.z   : 1'b0;
   assign flag_n    = out_valid ? head.n   : 1'b0;
   assign res_class = out_valid ? head.cls : 2'b00;

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: three instances (W8/D2, W8/D4, W16/D8) driven from one stimulus thread.
module tb_alu_result_queue;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [3:0] op_sel;
   logic [7:0] arith_res, logic_res, cmp_res, shift_res;

   logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [7:0] a_result;
   logic       a_flag_z, a_flag_n;
   logic [1:0] a_res_class;
   logic [1:0] a_count;

   logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [7:0] b_result;
   logic       b_flag_z, b_flag_n;
   logic [1:0] b_res_class;
   logic [2:0] b_count;

   logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
   logic [15:0] c_arith;
   logic [15:0] c_zero;
   logic [15:0] c_result;
   logic        c_flag_z, c_flag_n;
   logic [1:0]  c_res_class;
   logic [3:0]  c_count;

   alu_result_queue #(.WIDTH(8), .DEPTH(2)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .op_sel(op_sel),
      .arith_res(arith_res), .logic_res(logic_res), .cmp_res(cmp_res), .shift_res(shift_res),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .result(a_result), .flag_z(a_flag_z),
      .flag_n(a_flag_n), .res_class(a_res_class), .count(a_count)
   );

   alu_result_queue #(.WIDTH(8), .DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .op_sel(op_sel),
      .arith_res(arith_res), .logic_res(logic_res), .cmp_res(cmp_res), .shift_res(shift_res),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_result), .flag_z(b_flag_z),
      .flag_n(b_flag_n), .res_class(b_res_class), .count(b_count)
   );

   alu_result_queue #(.WIDTH(16), .DEPTH(8)) dut_c (
      .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .op_sel(4'd0),
      .arith_res(c_arith), .logic_res(c_zero), .cmp_res(c_zero), .shift_res(c_zero),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .result(c_result), .flag_z(c_flag_z),
      .flag_n(c_flag_n), .res_class(c_res_class), .count(c_count)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] op;
      logic [7:0] res;
      logic [1:0] cls;
   } vec_t;

   vec_t vecs [16];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      vecs[0]  = '{4'd0,  8'h11, 2'b00};
      vecs[1]  = '{4'd1,  8'h11, 2'b00};
      vecs[2]  = '{4'd2,  8'h11, 2'b00};
      vecs[3]  = '{4'd3,  8'h22, 2'b01};
      vecs[4]  = '{4'd4,  8'h22, 2'b01};
      vecs[5]  = '{4'd5,  8'h22, 2'b01};
      vecs[6]  = '{4'd6,  8'h22, 2'b01};
      vecs[7]  = '{4'd7,  8'h33, 2'b10};
      vecs[8]  = '{4'd8,  8'h11, 2'b00};
      vecs[9]  = '{4'd9,  8'h33, 2'b10};
      vecs[10] = '{4'd10, 8'h33, 2'b10};
      vecs[11] = '{4'd11, 8'h33, 2'b10};
      vecs[12] = '{4'd12, 8'h44, 2'b11};
      vecs[13] = '{4'd13, 8'h44, 2'b11};
      vecs[14] = '{4'd14, 8'h33, 2'b10};
      vecs[15] = '{4'd15, 8'h33, 2'b10};

      rst = 1'b1;
      op_sel = 4'd0;
      arith_res = 8'h11; logic_res = 8'h22; cmp_res = 8'h33; shift_res = 8'h44;
      a_in_valid = 1'b0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_out_ready = 1'b0;
      c_in_valid = 1'b0; c_out_ready = 1'b0; c_arith = 16'h0; c_zero = 16'h0;
      step();
      step();
      rst = 1'b0;

      chk("reset count", 32'(a_count), 32'd0);
      chk("reset out_valid", 32'(a_out_valid), 32'd0);
      chk("reset in_ready", 32'(a_in_ready), 32'd1);
      chk("reset result", 32'(a_result), 32'd0);
      chk("reset flag_z", 32'(a_flag_z), 32'd0);
      chk("reset class", 32'(a_res_class), 32'd0);

      // Decode sweep: one op per cycle, each visible right after its push edge.
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         op_sel = vecs[i].op;
         step();
         chk($sformatf("sweep result op%0d", i), 32'(a_result), 32'(vecs[i].res));
         chk($sformatf("sweep class op%0d", i), 32'(a_res_class), 32'(vecs[i].cls));
         chk($sformatf("sweep valid op%0d", i), 32'(a_out_valid), 32'd1);
         chk($sformatf("sweep count op%0d", i), 32'(a_count), 32'd1);
      end
      a_in_valid = 1'b0;
      step();
      chk("sweep drained", 32'(a_out_valid), 32'd0);

      // Flags
      op_sel = 4'd0; arith_res = 8'h00; a_out_ready = 1'b0; a_in_valid = 1'b1;
      step();
      chk("zero flag_z", 32'(a_flag_z), 32'd1);
      chk("zero flag_n", 32'(a_flag_n), 32'd0);
      arith_res = 8'h80; a_out_ready = 1'b1;
      step();
      chk("neg result", 32'(a_result), 32'h80);
      chk("neg flag_z", 32'(a_flag_z), 32'd0);
      chk("neg flag_n", 32'(a_flag_n), 32'd1);
      a_in_valid = 1'b0;
      step();
      chk("empty result", 32'(a_result), 32'd0);
      chk("empty flag_z", 32'(a_flag_z), 32'd0);
      chk("empty flag_n", 32'(a_flag_n), 32'd0);
      chk("empty class", 32'(a_res_class), 32'd0);

      // Backpressure / full
      a_out_ready = 1'b0; a_in_valid = 1'b1; arith_res = 8'h05;
      step();
      arith_res = 8'h06;
      step();
      chk("full count", 32'(a_count), 32'd2);
      chk("full in_ready", 32'(a_in_ready), 32'd0);
      arith_res = 8'h07;
      step();
      chk("full ignore count", 32'(a_count), 32'd2);
      chk("full head A", 32'(a_result), 32'h05);
      a_out_ready = 1'b1;
      step();
      chk("drain count 1", 32'(a_count), 32'd1);
      chk("drain head B", 32'(a_result), 32'h06);
      a_in_valid = 1'b0;
      step();
      chk("drain count 0", 32'(a_count), 32'd0);
      chk("drain no C", 32'(a_out_valid), 32'd0);

      // Simultaneous push/pop at count 1
      a_out_ready = 1'b0; a_in_valid = 1'b1; arith_res = 8'h0A;
      step();
      chk("pp head 0A", 32'(a_result), 32'h0A);
      arith_res = 8'h0B; a_out_ready = 1'b1;
      step();
      chk("pp count", 32'(a_count), 32'd1);
      chk("pp head 0B", 32'(a_result), 32'h0B);
      a_in_valid = 1'b0;
      step();
      chk("pp empty", 32'(a_count), 32'd0);

      // Reset mid-stream with a push in the reset cycle
      a_out_ready = 1'b0; a_in_valid = 1'b1; arith_res = 8'h21;
      step();
      arith_res = 8'h22;
      step();
      chk("pre-reset count", 32'(a_count), 32'd2);
      rst = 1'b1; arith_res = 8'h23;
      step();
      rst = 1'b0; a_in_valid = 1'b0;
      chk("mid reset count", 32'(a_count), 32'd0);
      chk("mid reset out_valid", 32'(a_out_valid), 32'd0);
      chk("mid reset in_ready", 32'(a_in_ready), 32'd1);
      chk("mid reset result", 32'(a_result), 32'd0);
      step();
      chk("reset push dropped", 32'(a_out_valid), 32'd0);

      // DEPTH=4: push/pop at count 3 across the pointer wrap
      b_out_ready = 1'b0; b_in_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         arith_res = 8'(i);
         step();
      end
      chk("d4 count 3", 32'(b_count), 32'd3);
      b_out_ready = 1'b1; arith_res = 8'h04;
      step();
      chk("d4 pp1 count", 32'(b_count), 32'd3);
      chk("d4 pp1 head", 32'(b_result), 32'h02);
      arith_res = 8'h05;
      step();
      chk("d4 pp2 count", 32'(b_count), 32'd3);
      chk("d4 pp2 head", 32'(b_result), 32'h03);
      b_in_valid = 1'b0;
      for (int i = 4; i <= 5; i++) begin
         step();
         chk($sformatf("d4 drain head %0d", i), 32'(b_result), 32'(i));
      end
      step();
      chk("d4 empty", 32'(b_out_valid), 32'd0);

      // WIDTH=16, DEPTH=8 fill and drain
      c_out_ready = 1'b0; c_in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         c_arith = 16'h8000 + 16'(i);
         step();
         chk($sformatf("d8 fill count %0d", i), 32'(c_count), 32'(i + 1));
      end
      chk("d8 full in_ready", 32'(c_in_ready), 32'd0);
      c_in_valid = 1'b0; c_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("d8 drain result %0d", i), 32'(c_result), 32'h8000 + 32'(i));
         chk($sformatf("d8 drain flag_n %0d", i), 32'(c_flag_n), 32'd1);
         step();
      end
      chk("d8 empty", 32'(c_out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
